// File: rtl/npc_seg_pkg.sv
// Shared seven-segment definitions: active-low {a,b,c,d,e,f,g} patterns.
package npc_seg_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'b1111111;

  localparam seg7_t SEG_HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/prio_enc_seg_scan_if.sv
// Switch-side request bundle and display-side result bundle of the encoder.
interface prio_enc_seg_scan_if
  import npc_seg_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DIGITS = 2
);
  localparam int IDX_W = $clog2(IN_W);

  logic [IN_W-1:0]   x;
  logic              en;
  logic              hold;
  logic [IDX_W-1:0]  idx;
  logic              valid;
  logic              changed;
  seg7_t             seg;
  logic [DIGITS-1:0] an;

  modport master (
    output x, en, hold,
    input  idx, valid, changed, seg, an
  );

  modport slave (
    input  x, en, hold,
    output idx, valid, changed, seg, an
  );

endinterface

// File: rtl/seg7_hex_dec.sv
// Combinational hex-nibble to active-low seven-segment decoder with blanking.
module seg7_hex_dec
  import npc_seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output seg7_t      seg
);

  assign seg = blank ? SEG_BLANK : SEG_HEX[nib];

endmodule

// File: rtl/prio_enc_seg_scan.sv
// Registered priority encoder (1-cycle latency) with hold control, driving a
// time-multiplexed hex display that scans one digit per SCAN_DIV cycles.
module prio_enc_seg_scan
  import npc_seg_pkg::*;
#(
  parameter int IN_W     = 8,
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 1000
)(
  input  logic                clk,
  input  logic                rst_n,
  prio_enc_seg_scan_if.slave  bus
);

  localparam int IDX_W = $clog2(IN_W);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DIGITS - 1);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              changed_q, changed_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [DIGITS-1:0] an_q, an_d;
  seg7_t             seg_q, seg_d;

  logic [IDX_W-1:0]  enc;
  logic [3:0]        nib;
  seg7_t             dec_seg;

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    enc = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (bus.x[i]) enc = IDX_W'(i);
    end
  end

  always_comb begin
    idx_d     = idx_q;
    valid_d   = valid_q;
    changed_d = 1'b0;
    if (!bus.hold) begin
      valid_d   = bus.en && (|bus.x);
      idx_d     = valid_d ? enc : '0;
      changed_d = (valid_d != valid_q) || (idx_d != idx_q);
    end
  end

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    ptr_d = ptr_q;
    if (cnt_q == CNT_LAST) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  // Digits above the index width shift in zeros and therefore show 0.
  always_comb begin
    nib  = 4'(idx_q >> (4 * int'(ptr_q)));
    an_d = ~(DIGITS'(1) << ptr_q);
    seg_d = dec_seg;
  end

  seg7_hex_dec u_dec (
    .nib   (nib),
    .blank (~valid_q),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      an_q      <= '1;
      seg_q     <= SEG_BLANK;
    end else begin
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign bus.idx     = idx_q;
  assign bus.valid   = valid_q;
  assign bus.changed = changed_q;
  assign bus.an      = an_q;
  assign bus.seg     = seg_q;

endmodule

// File: tb/tb_prio_enc_seg_scan.sv
// Scoreboarded bench: three encoder/display configurations against a cycle-count model.
module tb_prio_enc_seg_scan;

  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  prio_enc_seg_scan_if #(.IN_W(8),  .DIGITS(2)) if0 ();
  prio_enc_seg_scan_if #(.IN_W(32), .DIGITS(2)) if1 ();
  prio_enc_seg_scan_if #(.IN_W(8),  .DIGITS(1)) if2 ();

  prio_enc_seg_scan #(.IN_W(8),  .DIGITS(2), .SCAN_DIV(SD)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  prio_enc_seg_scan #(.IN_W(32), .DIGITS(2), .SCAN_DIV(SD)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  prio_enc_seg_scan #(.IN_W(8),  .DIGITS(1), .SCAN_DIV(SD)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  typedef struct {
    int dut;
    int cyc;
    int idx;
    int valid;
    int changed;
    int an;
    int seg;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  int P_W [3] = '{8, 32, 8};
  int P_D [3] = '{2, 2, 1};
  int HEX [16] = '{'h01, 'h4F, 'h12, 'h06, 'h4C, 'h24, 'h20, 'h0F,
                   'h00, 'h04, 'h08, 'h60, 'h31, 'h42, 'h30, 'h38};

  int m_idx   [3] = '{0, 0, 0};
  int m_valid [3] = '{0, 0, 0};
  int m_k     [3] = '{0, 0, 0};

  task automatic chk(string name, int j, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc%0d: got %0h expected %0h", name, j, cyc, act, exp);
    end
  endtask

  function automatic int highest(logic [31:0] x, int w);
    for (int i = w - 1; i >= 0; i--) if (x[i]) return i;
    return 0;
  endfunction

  // Display digit at the k-th edge after release follows from elapsed cycles alone.
  function automatic exp_t model_edge(int j, int run, logic [31:0] x, int en, int hold);
    exp_t e;
    int ptr, nib, nv, ni, mask;
    e.dut = j;
    e.cyc = cyc + 1;
    mask  = (1 << P_D[j]) - 1;
    if (!run) begin
      m_idx[j] = 0; m_valid[j] = 0; m_k[j] = 0;
      e.idx = 0; e.valid = 0; e.changed = 0; e.an = mask; e.seg = 'h7F;
      return e;
    end
    m_k[j]++;
    ptr   = ((m_k[j] - 1) / SD) % P_D[j];
    nib   = (m_idx[j] >> (4 * ptr)) & 15;
    e.seg = m_valid[j] ? HEX[nib] : 'h7F;
    e.an  = mask & ~(1 << ptr);
    e.changed = 0;
    if (!hold) begin
      nv = (en != 0 && x != 0) ? 1 : 0;
      ni = nv ? highest(x, P_W[j]) : 0;
      e.changed = (nv != m_valid[j] || ni != m_idx[j]) ? 1 : 0;
      m_valid[j] = nv;
      m_idx[j]   = ni;
    end
    e.idx   = m_idx[j];
    e.valid = m_valid[j];
    return e;
  endfunction

  task automatic step(input int run, input logic [7:0] x8, input logic [31:0] x32,
                      input int en, input int hold);
    @(posedge clk);
    #1;
    rst_n   = run[0];
    if0.x   = x8;  if2.x = x8;  if1.x = x32;
    if0.en  = en[0];  if1.en  = en[0];  if2.en  = en[0];
    if0.hold = hold[0]; if1.hold = hold[0]; if2.hold = hold[0];
    for (int j = 0; j < 3; j++) sb.push_back(model_edge(j, run, (j == 1) ? x32 : 32'(x8), en, hold));
  endtask

  task automatic steps(input int n, input logic [7:0] x8, input logic [31:0] x32,
                       input int en, input int hold);
    for (int i = 0; i < n; i++) step(1, x8, x32, en, hold);
  endtask

  function automatic void get_out(int j, output logic [31:0] idx, output logic [31:0] v,
                                  output logic [31:0] ch, output logic [31:0] an,
                                  output logic [31:0] seg);
    case (j)
      0: begin idx = 32'(if0.idx); v = 32'(if0.valid); ch = 32'(if0.changed); an = 32'(if0.an); seg = 32'(if0.seg); end
      1: begin idx = 32'(if1.idx); v = 32'(if1.valid); ch = 32'(if1.changed); an = 32'(if1.an); seg = 32'(if1.seg); end
      default: begin idx = 32'(if2.idx); v = 32'(if2.valid); ch = 32'(if2.changed); an = 32'(if2.an); seg = 32'(if2.seg); end
    endcase
  endfunction

  // Mid-cycle reset: outputs must clear before any further clock edge.
  task automatic async_reset;
    logic [31:0] idx, v, ch, an, seg;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    for (int j = 0; j < 3; j++) sb.push_back(model_edge(j, 0, 0, 0, 0));
    #1;
    for (int j = 0; j < 3; j++) begin
      get_out(j, idx, v, ch, an, seg);
      chk("rst_async_seg", j, seg, 'h7F);
      chk("rst_async_an", j, an, (1 << P_D[j]) - 1);
      chk("rst_async_idx", j, idx, 0);
      chk("rst_async_valid", j, v, 0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] idx, v, ch, an, seg;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        chk("sb_stale", e.dut, e.cyc, cyc);
      end else begin
        get_out(e.dut, idx, v, ch, an, seg);
        chk("idx", e.dut, idx, e.idx);
        chk("valid", e.dut, v, e.valid);
        chk("changed", e.dut, ch, e.changed);
        chk("an", e.dut, an, e.an);
        chk("seg", e.dut, seg, e.seg);
      end
    end
  end

  initial begin
    logic [7:0]  rx8;
    logic [31:0] rx32;
    int ren, rhold, sel;

    if0.x = '0; if1.x = '0; if2.x = '0;
    if0.en = 1'b0; if1.en = 1'b0; if2.en = 1'b0;
    if0.hold = 1'b0; if1.hold = 1'b0; if2.hold = 1'b0;

    for (int i = 0; i < 3; i++) step(0, 8'h00, 32'h0, 0, 0);
    // Scan pattern with blank display, then the first encodes.
    steps(9, 8'h00, 32'h0, 0, 0);
    steps(9, 8'b0010_0110, 32'h0000_0026, 1, 0);
    steps(3, 8'h00, 32'h0, 1, 0);
    steps(9, 8'h01, 32'h1, 1, 0);
    steps(3, 8'h80, 32'h80, 1, 1);
    steps(3, 8'h03, 32'h3, 1, 1);
    steps(3, 8'h03, 32'h3, 1, 0);
    steps(3, 8'hFF, 32'hFFFF_FFFF, 0, 0);
    steps(9, 8'hFF, 32'hFFFF_FFFF, 1, 0);
    steps(3, 8'h00, 32'h0, 0, 1);
    steps(10, 8'h40, 32'h8000_0000, 1, 0);

    async_reset();
    step(0, 8'h10, 32'h10, 1, 0);
    step(0, 8'h10, 32'h10, 1, 0);
    steps(10, 8'h10, 32'h0001_0000, 1, 0);

    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 3);
      rx8  = 8'($urandom);
      rx32 = $urandom >> $urandom_range(0, 31);
      if (sel == 0) begin
        rx8  = 8'(1 << $urandom_range(0, 7));
        rx32 = 32'h1 << $urandom_range(0, 31);
      end else if (sel == 1 && $urandom_range(0, 2) == 0) begin
        rx8 = 8'h00; rx32 = 32'h0;
      end
      ren   = ($urandom_range(0, 7) != 0) ? 1 : 0;
      rhold = ($urandom_range(0, 5) == 0) ? 1 : 0;
      steps($urandom_range(1, 6), rx8, rx32, ren, rhold);
    end

    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_drained", 0, sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
